// File: rtl/vga_sync_gen.sv
// Pixel-rate VGA timing generator: position counters plus a registered decode of
// sync, active-video, coordinates and line/frame strobes, all aligned to one pixel.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  output logic       vga_h_sync,
  output logic       vga_v_sync,
  output logic       active,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned CW       = 10;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  logic [CW-1:0] r_h_cnt;
  logic [CW-1:0] r_v_cnt;
  logic          r_h_sync;
  logic          r_v_sync;
  logic          r_active;
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          r_line_start;
  logic          r_frame_start;

  logic          w_h_wrap;
  logic [CW-1:0] w_h_next;
  logic [CW-1:0] w_v_next;
  logic          w_active;
  logic          w_hs_on;
  logic          w_vs_on;

  // Next scan position and its decode; outputs register this on an enabled edge.
  always_comb begin
    w_h_wrap = 1'b0;
    w_h_next = '0;
    w_v_next = r_v_cnt;
    w_active = 1'b0;
    w_hs_on  = 1'b0;
    w_vs_on  = 1'b0;

    w_h_wrap = (r_h_cnt == H_LAST);
    w_h_next = w_h_wrap ? '0 : r_h_cnt + CW'(1);
    if (w_h_wrap) begin
      w_v_next = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + CW'(1);
    end

    w_active = (32'(w_h_next) < H_ACTIVE) && (32'(w_v_next) < V_ACTIVE);
    w_hs_on  = (32'(w_h_next) >= HS_START) && (32'(w_h_next) < HS_END);
    w_vs_on  = (32'(w_v_next) >= VS_START) && (32'(w_v_next) < VS_END);
  end

  // Reset parks the counters on the last pixel so the first enabled edge lands on (0,0).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h_cnt       <= H_LAST;
      r_v_cnt       <= V_LAST;
      r_h_sync      <= ~SYNC_POL;
      r_v_sync      <= ~SYNC_POL;
      r_active      <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (ce) begin
      r_h_cnt       <= w_h_next;
      r_v_cnt       <= w_v_next;
      r_h_sync      <= w_hs_on ? SYNC_POL : ~SYNC_POL;
      r_v_sync      <= w_vs_on ? SYNC_POL : ~SYNC_POL;
      r_active      <= w_active;
      r_x           <= w_h_next;
      r_y           <= w_v_next;
      r_line_start  <= (w_h_next == '0);
      r_frame_start <= (w_h_next == '0) && (w_v_next == '0);
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign vga_h_sync  = r_h_sync;
  assign vga_v_sync  = r_v_sync;
  assign active      = r_active;
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule
